// File: rtl/mult_pkg.sv
// mult_pkg: shared constants, stage record and carry-add helper for the reduce path; MULT_REDUCE_OVF_EN adds the overflow bit
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_TAG_W = 32;
  localparam int MULT_NUM_PP = 8;
  localparam int MULT_REDUCE_LAT = 3;
`ifdef MULT_REDUCE_OVF_EN
  localparam int MULT_OVF_BITS = 1;
`else
  localparam int MULT_OVF_BITS = 0;
`endif
  typedef struct packed {
    logic valid;
    logic ovf;
    logic [MULT_TAG_W-1:0] tag;
    logic [MULT_WIDTH-1:0] data;
  } stage_t;
  function automatic logic [MULT_WIDTH:0] add_c(input logic [MULT_WIDTH-1:0] a, input logic [MULT_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/mult_reduce_slice.sv
// mult_reduce_slice: one pipeline stage register (valid, side word, N data words) with stall enable and sync reset
module mult_reduce_slice #(
  parameter int N = 1,
  parameter int W = 32,
  parameter int SW = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                d_valid,
  input  logic [SW-1:0]       d_side,
  input  logic [N-1:0][W-1:0] d_data,
  output logic                q_valid,
  output logic [SW-1:0]       q_side,
  output logic [N-1:0][W-1:0] q_data
);
  // valid advances every unstalled cycle; payload loads only with a valid entry so bubbles leave it untouched
  always_ff @(posedge clock)
    if (reset) begin
      q_valid <= 1'b0;
      q_side <= '0;
      q_data <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      if (d_valid) begin
        q_side <= d_side;
        q_data <= d_data;
      end
    end
endmodule

// File: rtl/mult_reduce_stage.sv
// mult_reduce_stage: 3-stage registered 8->4->2->1 adder tree carrying valid and side word, global stall; MULT_REDUCE_OVF_EN adds overflow
module mult_reduce_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int TAG_W = MULT_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] input_0,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic [WIDTH-1:0] input_3,
  input  logic [WIDTH-1:0] input_4,
  input  logic [WIDTH-1:0] input_5,
  input  logic [WIDTH-1:0] input_6,
  input  logic [WIDTH-1:0] input_7,
  input  logic [TAG_W-1:0] reg_input,
  output logic             out_valid,
  output logic [WIDTH-1:0] product,
  output logic [TAG_W-1:0] reg_output,
  output logic             busy,
  output logic             overflow
);
  localparam int SW = TAG_W + MULT_OVF_BITS;
  logic [MULT_NUM_PP-1:0][WIDTH-1:0] pp;
  logic [3:0][WIDTH-1:0] s1_d, s1_q;
  logic [1:0][WIDTH-1:0] s2_d, s2_q;
  logic [WIDTH-1:0] s3_d, s3_q;
  logic [SW-1:0] s1_sd, s1_sq, s2_sd, s2_sq, s3_sd, s3_sq;
  logic [MULT_REDUCE_LAT-1:0] v;
  logic s3_ovf;
  stage_t s3;
  assign pp = {input_7, input_6, input_5, input_4, input_3, input_2, input_1, input_0};
`ifdef MULT_REDUCE_OVF_EN
  logic [3:0] c1;
  logic [1:0] c2;
  logic c3;
  // tree adds keep their carries; the side word's top bit accumulates them per entry
  always_comb begin
    for (int k = 0; k < 4; k++) {c1[k], s1_d[k]} = add_c(pp[2*k], pp[2*k+1]);
    for (int j = 0; j < 2; j++) {c2[j], s2_d[j]} = add_c(s1_q[2*j], s1_q[2*j+1]);
    {c3, s3_d} = add_c(s2_q[0], s2_q[1]);
  end
  assign s1_sd = {|c1, reg_input};
  assign s2_sd = {s1_sq[TAG_W] | (|c2), s1_sq[TAG_W-1:0]};
  assign s3_sd = {s2_sq[TAG_W] | c3, s2_sq[TAG_W-1:0]};
  assign s3_ovf = s3_sq[TAG_W];
`else
  // plain wrapping tree adds
  always_comb begin
    for (int k = 0; k < 4; k++) s1_d[k] = pp[2*k] + pp[2*k+1];
    for (int j = 0; j < 2; j++) s2_d[j] = s1_q[2*j] + s1_q[2*j+1];
    s3_d = s2_q[0] + s2_q[1];
  end
  assign s1_sd = reg_input;
  assign s2_sd = s1_sq;
  assign s3_sd = s2_sq;
  assign s3_ovf = 1'b0;
`endif
  mult_reduce_slice #(.N(4), .W(WIDTH), .SW(SW)) u_s1 (
    .clock(clock), .reset(reset), .en(!stall), .d_valid(in_valid), .d_side(s1_sd), .d_data(s1_d),
    .q_valid(v[0]), .q_side(s1_sq), .q_data(s1_q)
  );
  mult_reduce_slice #(.N(2), .W(WIDTH), .SW(SW)) u_s2 (
    .clock(clock), .reset(reset), .en(!stall), .d_valid(v[0]), .d_side(s2_sd), .d_data(s2_d),
    .q_valid(v[1]), .q_side(s2_sq), .q_data(s2_q)
  );
  mult_reduce_slice #(.N(1), .W(WIDTH), .SW(SW)) u_s3 (
    .clock(clock), .reset(reset), .en(!stall), .d_valid(v[1]), .d_side(s3_sd), .d_data(s3_d),
    .q_valid(v[2]), .q_side(s3_sq), .q_data(s3_q)
  );
  assign s3 = '{valid: v[2], ovf: s3_ovf, tag: s3_sq[TAG_W-1:0], data: s3_q};
  assign out_valid = s3.valid;
  assign product = s3.data;
  assign reg_output = s3.tag;
  assign overflow = s3.valid & s3.ovf;
  assign busy = |v;
endmodule

// File: tb/tb_mult_reduce_stage.sv
// tb_mult_reduce_stage: table-driven vectors with a scoreboard queue plus hand sequences for latency, stall and reset
module tb_mult_reduce_stage;
  typedef struct {
    logic [31:0] pp [8];
    logic [31:0] tag;
    logic [31:0] prod;
    logic ovf;
  } vec_t;
  typedef struct {
    logic [31:0] prod;
    logic [31:0] tag;
    logic ovf;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic stall = 1'b0;
  logic [31:0] tin [8];
  logic [31:0] tag_in = '0;
  logic out_valid, busy, overflow;
  logic [31:0] product, reg_output;
  vec_t tbl [14];
  exp_t sb [$];
  int checks = 0;
  int passed = 0;
  always #5 clock = ~clock;
  mult_reduce_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall),
    .input_0(tin[0]), .input_1(tin[1]), .input_2(tin[2]), .input_3(tin[3]),
    .input_4(tin[4]), .input_5(tin[5]), .input_6(tin[6]), .input_7(tin[7]),
    .reg_input(tag_in), .out_valid(out_valid), .product(product), .reg_output(reg_output),
    .busy(busy), .overflow(overflow)
  );
  function automatic logic eo(input logic o);
`ifdef MULT_REDUCE_OVF_EN
    return o;
`else
    return 1'b0 & o;
`endif
  endfunction
  function automatic vec_t mk(input logic [31:0] val, input logic [31:0] tag, input logic [31:0] prod, input logic ovf);
    vec_t r;
    for (int k = 0; k < 8; k++) r.pp[k] = val;
    r.tag = tag;
    r.prod = prod;
    r.ovf = ovf;
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input int i, input logic v);
    for (int k = 0; k < 8; k++) tin[k] = tbl[i].pp[k];
    tag_in = tbl[i].tag;
    in_valid = v;
    if (v && !stall && !reset) sb.push_back('{prod: tbl[i].prod, tag: tbl[i].tag, ovf: eo(tbl[i].ovf)});
    step();
  endtask
  // scoreboard: each unstalled out_valid cycle consumes exactly one expected result
  always @(negedge clock)
    if (!reset && !stall) begin
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", product, e.prod);
          chk("reg_output", reg_output, e.tag);
          chk("overflow", overflow, e.ovf);
        end
      end else chk("overflow_idle", overflow, 0);
    end
  initial begin
    int first, last, n;
    logic [63:0] s64;
    tbl[0] = mk(0, 32'hA5, 36, 0);
    for (int k = 0; k < 8; k++) tbl[0].pp[k] = k + 1;
    for (int k = 1; k <= 4; k++) tbl[k] = mk(k, k, 8 * k, 0);
    tbl[5] = mk(32'hFFFF_FFFF, 5, 32'hFFFF_FFF8, 1);
    tbl[6] = mk(0, 6, 0, 1);
    tbl[6].pp[0] = 32'h8000_0000;
    tbl[6].pp[1] = 32'h8000_0000;
    tbl[7] = mk(32'h2000_0000, 7, 0, 1);
    tbl[8] = mk(0, 8, 0, 1);
    tbl[8].pp[6] = 32'hFFFF_FFFF;
    tbl[8].pp[7] = 1;
    tbl[9] = tbl[0];
    tbl[9].tag = 32'h3C;
    for (int i = 10; i < 14; i++) begin
      s64 = '0;
      for (int k = 0; k < 8; k++) begin
        tbl[i].pp[k] = $urandom;
        s64 += {32'h0, tbl[i].pp[k]};
      end
      tbl[i].tag = $urandom;
      tbl[i].prod = s64[31:0];
      tbl[i].ovf = |s64[63:32];
    end
    for (int k = 0; k < 8; k++) tin[k] = $urandom;
    in_valid = 1'b1;
    stall = 1'(($urandom) & 1);
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_reg_output", reg_output, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    step();
    send(0, 1);
    chk("lat_e1", out_valid, 0);
    chk("busy_e1", busy, 1);
    send(0, 0);
    chk("lat_e2", out_valid, 0);
    send(0, 0);
    chk("lat_e3", out_valid, 1);
    chk("lat_product", product, 36);
    chk("lat_reg_output", reg_output, 32'hA5);
    send(0, 0);
    chk("lat_e4_drop", out_valid, 0);
    chk("hold_product", product, 36);
    first = -1;
    last = -1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) send(1 + c, 1);
      else send(1, 0);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        n++;
      end
    end
    chk("burst_count", n, 4);
    chk("burst_contiguous", last - first + 1, 4);
    send(9, 1);
    stall = 1'b1;
    send(0, 1);
    send(0, 1);
    stall = 1'b0;
    send(0, 0);
    chk("stall_e4", out_valid, 0);
    send(0, 0);
    chk("stall_e5", out_valid, 1);
    chk("stall_product", product, 36);
    chk("stall_reg_output", reg_output, 32'h3C);
    stall = 1'b1;
    send(0, 0);
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_product", product, 36);
    stall = 1'b0;
    send(0, 0);
    chk("stall_pulse_end", out_valid, 0);
    chk("stall_busy_end", busy, 0);
    for (int i = 5; i < 14; i++) send(i, 1);
    for (int c = 0; c < 5; c++) send(0, 0);
    chk("table_drained", sb.size(), 0);
    send(0, 1);
    send(0, 0);
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_product", product, 0);
    for (int c = 0; c < 6; c++) begin
      chk("midrst_no_out", out_valid, 0);
      step();
    end
    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
